// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, 12-bit colour type, colour constants and the reset palette.
package vga_pkg;

    localparam int unsigned DEF_HD = 640;
    localparam int unsigned DEF_HF = 16;
    localparam int unsigned DEF_HR = 96;
    localparam int unsigned DEF_HB = 48;
    localparam int unsigned DEF_VD = 480;
    localparam int unsigned DEF_VF = 10;
    localparam int unsigned DEF_VR = 2;
    localparam int unsigned DEF_VB = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb12_t WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb12_t RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb12_t GREEN = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb12_t BLUE  = '{r: 4'h0, g: 4'h0, b: 4'hF};

    typedef enum logic {
        DBUF_IDLE    = 1'b0,
        DBUF_PENDING = 1'b1
    } dbuf_state_t;

    // Palette contents after reset; entries beyond the first four are black.
    function automatic rgb12_t pal_reset(input int unsigned idx);
        case (idx)
            0:       return BLACK;
            1:       return WHITE;
            2:       return RED;
            3:       return GREEN;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v raster counters with visible flag, screen x/y and raw active-high syncs.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned HD = DEF_HD,
    parameter int unsigned HF = DEF_HF,
    parameter int unsigned HR = DEF_HR,
    parameter int unsigned HB = DEF_HB,
    parameter int unsigned VD = DEF_VD,
    parameter int unsigned VF = DEF_VF,
    parameter int unsigned VR = DEF_VR,
    parameter int unsigned VB = DEF_VB,
    localparam int unsigned HTOT = HR + HB + HD + HF,
    localparam int unsigned VTOT = VR + VB + VD + VF,
    localparam int unsigned HCW  = $clog2(HTOT),
    localparam int unsigned VCW  = $clog2(VTOT),
    localparam int unsigned XW   = $clog2(HD),
    localparam int unsigned YW   = $clog2(VD)
) (
    input  logic           clk,
    input  logic           arstn,
    output logic [HCW-1:0] hcount,
    output logic [VCW-1:0] vcount,
    output logic           visible_c,
    output logic [XW-1:0]  x_c,
    output logic [YW-1:0]  y_c,
    output logic           hsync_c,
    output logic           vsync_c,
    output logic           frame_end_c,
    output logic           frame_first_c
);

    localparam int unsigned HSTART = HR + HB;
    localparam int unsigned VSTART = VR + VB;

    logic line_end_c;

    // Line order is sync, back porch, display, front porch.
    always_ff @(posedge clk or negedge arstn) begin : cnt_p
        if (!arstn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end_c) begin
            hcount <= '0;
            vcount <= frame_end_c ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    always_comb begin : decode_p
        line_end_c    = (32'(hcount) == HTOT - 1);
        frame_end_c   = line_end_c && (32'(vcount) == VTOT - 1);
        visible_c     = (32'(hcount) >= HSTART) && (32'(hcount) < HSTART + HD) &&
                        (32'(vcount) >= VSTART) && (32'(vcount) < VSTART + VD);
        x_c           = XW'(32'(hcount) - HSTART);
        y_c           = YW'(32'(vcount) - VSTART);
        hsync_c       = (32'(hcount) < HR);
        vsync_c       = (32'(vcount) < VR);
        frame_first_c = (32'(hcount) == HSTART) && (32'(vcount) == VSTART);
    end

endmodule

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: VGA controller with indexed-colour framebuffer, writable palette and pixel replication.
// Define VGA_FB_DBUF_EN for double buffering with frame-synchronous swap; default is a single buffer.
module vga_fb_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned HD         = DEF_HD,
    parameter int unsigned HF         = DEF_HF,
    parameter int unsigned HR         = DEF_HR,
    parameter int unsigned HB         = DEF_HB,
    parameter int unsigned VD         = DEF_VD,
    parameter int unsigned VF         = DEF_VF,
    parameter int unsigned VR         = DEF_VR,
    parameter int unsigned VB         = DEF_VB,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned BPP        = 2,
    parameter int unsigned SCALE_LOG2 = 1,
    localparam int unsigned FB_W      = HD >> SCALE_LOG2,
    localparam int unsigned FB_H      = VD >> SCALE_LOG2,
    localparam int unsigned XW        = $clog2(FB_W),
    localparam int unsigned YW        = $clog2(FB_H)
) (
    input  logic           clk,
    input  logic           arstn,
    input  logic           wr_valid_i,
    output logic           wr_ready_o,
    input  logic [XW-1:0]  wr_x_i,
    input  logic [YW-1:0]  wr_y_i,
    input  logic [BPP-1:0] wr_data_i,
    output logic           wr_err_o,
    input  logic           pal_we_i,
    input  logic [BPP-1:0] pal_idx_i,
    input  logic [11:0]    pal_data_i,
    input  logic           swap_req_i,
    output logic           vga_hs_o,
    output logic           vga_vs_o,
    output logic           de_o,
    output logic [11:0]    rgb_o,
    output logic           frame_start_o
);

    localparam int unsigned DEPTH = FB_W * FB_H;
    localparam int unsigned AW    = $clog2(DEPTH);
`ifdef VGA_FB_DBUF_EN
    localparam int unsigned NBUF  = 2;
`else
    localparam int unsigned NBUF  = 1;
`endif
    localparam int unsigned MW    = $clog2(NBUF * DEPTH);
    localparam int unsigned NPAL  = 2 ** BPP;
    localparam int unsigned HCW   = $clog2(HR + HB + HD + HF);
    localparam int unsigned VCW   = $clog2(VR + VB + VD + VF);
    localparam int unsigned TXW   = $clog2(HD);
    localparam int unsigned TYW   = $clog2(VD);

    logic [HCW-1:0] hcount;
    logic [VCW-1:0] vcount;
    logic           visible_c, hsync_c, vsync_c, frame_end_c, frame_first_c;
    logic [TXW-1:0] tx_c;
    logic [TYW-1:0] ty_c;

    vga_timing #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB)
    ) u_timing (
        .clk           (clk),
        .arstn         (arstn),
        .hcount        (hcount),
        .vcount        (vcount),
        .visible_c     (visible_c),
        .x_c           (tx_c),
        .y_c           (ty_c),
        .hsync_c       (hsync_c),
        .vsync_c       (vsync_c),
        .frame_end_c   (frame_end_c),
        .frame_first_c (frame_first_c)
    );

    logic unused_cnt_c;
    assign unused_cnt_c = ^{hcount, vcount};

    logic front, back, ready_c;

`ifdef VGA_FB_DBUF_EN
    dbuf_state_t state, state_nxt;
    logic        swap_c;

    always_ff @(posedge clk or negedge arstn) begin : dbuf_state_p
        if (!arstn) state <= DBUF_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin : dbuf_nxt_p
        state_nxt = state;
        case (state)
            DBUF_IDLE:    if (swap_req_i)  state_nxt = DBUF_PENDING;
            DBUF_PENDING: if (frame_end_c) state_nxt = DBUF_IDLE;
            default:      state_nxt = DBUF_IDLE;
        endcase
    end

    // Writes stall while a swap waits for the end of the frame.
    always_comb begin : dbuf_out_p
        swap_c  = 1'b0;
        ready_c = 1'b1;
        swap_c  = (state == DBUF_PENDING) && frame_end_c;
        ready_c = (state_nxt == DBUF_IDLE);
    end

    always_ff @(posedge clk or negedge arstn) begin : front_p
        if (!arstn)      front <= 1'b0;
        else if (swap_c) front <= ~front;
    end

    assign back = ~front;
`else
    assign front   = 1'b0;
    assign back    = 1'b0;
    assign ready_c = 1'b1;

    logic unused_swap_c;
    assign unused_swap_c = swap_req_i ^ frame_end_c;
`endif

    // Display-side address: each framebuffer pixel spans 2**SCALE_LOG2 screen pixels both ways.
    logic [AW-1:0] fb_addr_c;
    logic [MW-1:0] rd_idx_c, wr_idx_c;
    logic          in_range_c, wr_acc_c, wr_en_c;

    always_comb begin : addr_p
        fb_addr_c  = AW'((32'(ty_c) >> SCALE_LOG2) * FB_W + (32'(tx_c) >> SCALE_LOG2));
        rd_idx_c   = MW'(32'(front) * DEPTH + 32'(fb_addr_c));
        in_range_c = (32'(wr_x_i) < FB_W) && (32'(wr_y_i) < FB_H);
        wr_acc_c   = wr_valid_i && wr_ready_o;
        wr_en_c    = wr_acc_c && in_range_c;
        wr_idx_c   = MW'(32'(back) * DEPTH + 32'(wr_y_i) * FB_W + 32'(wr_x_i));
    end

    always_ff @(posedge clk or negedge arstn) begin : wr_ctl_p
        if (!arstn) begin
            wr_ready_o <= 1'b0;
            wr_err_o   <= 1'b0;
        end else begin
            wr_ready_o <= ready_c;
            wr_err_o   <= wr_acc_c && !in_range_c;
        end
    end

    logic [BPP-1:0] mem [NBUF*DEPTH];
    logic [MW-1:0]  s1_idx;
    logic           s1_vis, s1_hs, s1_vs, s1_fs;
    logic [BPP-1:0] s2_pix;
    logic           s2_vis, s2_hs, s2_vs, s2_fs;

    // Framebuffer RAM, not reset; a same-cycle write and read return the old data.
    always_ff @(posedge clk) begin : ram_p
        if (wr_en_c) mem[wr_idx_c] <= wr_data_i;
        s2_pix <= mem[s1_idx];
    end

    rgb12_t pal [NPAL];

    always_ff @(posedge clk or negedge arstn) begin : pal_p
        if (!arstn) begin
            for (int i = 0; i < NPAL; i++) pal[i] <= pal_reset(i);
        end else if (pal_we_i) begin
            pal[pal_idx_i] <= rgb12_t'(pal_data_i);
        end
    end

    // Three-stage pipeline: address, RAM read, palette; controls ride alongside.
    always_ff @(posedge clk or negedge arstn) begin : pipe_p
        if (!arstn) begin
            s1_idx        <= '0;
            s1_vis        <= 1'b0;
            s1_hs         <= 1'b0;
            s1_vs         <= 1'b0;
            s1_fs         <= 1'b0;
            s2_vis        <= 1'b0;
            s2_hs         <= 1'b0;
            s2_vs         <= 1'b0;
            s2_fs         <= 1'b0;
            de_o          <= 1'b0;
            vga_hs_o      <= ~HS_POL;
            vga_vs_o      <= ~VS_POL;
            frame_start_o <= 1'b0;
            rgb_o         <= '0;
        end else begin
            s1_idx        <= rd_idx_c;
            s1_vis        <= visible_c;
            s1_hs         <= hsync_c;
            s1_vs         <= vsync_c;
            s1_fs         <= frame_first_c;
            s2_vis        <= s1_vis;
            s2_hs         <= s1_hs;
            s2_vs         <= s1_vs;
            s2_fs         <= s1_fs;
            de_o          <= s2_vis;
            vga_hs_o      <= s2_hs ? HS_POL : ~HS_POL;
            vga_vs_o      <= s2_vs ? VS_POL : ~VS_POL;
            frame_start_o <= s2_fs;
            rgb_o         <= s2_vis ? pal[s2_pix] : BLACK;
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: directed checks of raster timing, framebuffer writes, palette and reset on a small raster.
module tb_vga_fb_ctrl;

    // Raster: 27 clocks per line, 16 lines per frame; framebuffer 10 x 6.
    localparam int unsigned HD = 20, HF = 2, HR = 3, HB = 2;
    localparam int unsigned VD = 12, VF = 1, VR = 2, VB = 1;
    localparam int HTOT  = 27;
    localparam int FRAME = 432;
    localparam int PIPE  = 3;

    logic        clk = 1'b0;
    logic        arstn;
    logic        wr_valid_i, wr_ready_o, wr_err_o;
    logic [3:0]  wr_x_i;
    logic [2:0]  wr_y_i;
    logic [1:0]  wr_data_i;
    logic        pal_we_i;
    logic [1:0]  pal_idx_i;
    logic [11:0] pal_data_i;
    logic        swap_req_i;
    logic        vga_hs_o, vga_vs_o, de_o, frame_start_o;
    logic [11:0] rgb_o;

    vga_fb_ctrl #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB),
        .HS_POL(1'b1), .VS_POL(1'b0), .BPP(2), .SCALE_LOG2(1)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_x_i        (wr_x_i),
        .wr_y_i        (wr_y_i),
        .wr_data_i     (wr_data_i),
        .wr_err_o      (wr_err_o),
        .pal_we_i      (pal_we_i),
        .pal_idx_i     (pal_idx_i),
        .pal_data_i    (pal_data_i),
        .swap_req_i    (swap_req_i),
        .vga_hs_o      (vga_hs_o),
        .vga_vs_o      (vga_vs_o),
        .de_o          (de_o),
        .rgb_o         (rgb_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; equals the DUT raster position modulo the frame.
    int cyc;
    always @(posedge clk or negedge arstn) begin
        if (!arstn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample clock at which screen pixel (sx,sy) of frame f appears on the outputs.
    function automatic int kpix(input int f, input int sx, input int sy);
        return f * FRAME + (VR + VB + sy) * HTOT + HR + HB + sx + PIPE;
    endfunction

    task automatic run_to(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) chk("run_to", cyc, k);
    endtask

    task automatic fb_write(input int x, input int y, input int d);
        wr_valid_i = 1'b1;
        wr_x_i     = 4'(x);
        wr_y_i     = 3'(y);
        wr_data_i  = 2'(d);
        @(negedge clk);
        wr_valid_i = 1'b0;
    endtask

    task automatic pal_write(input int idx, input logic [11:0] d);
        pal_we_i   = 1'b1;
        pal_idx_i  = 2'(idx);
        pal_data_i = d;
        @(negedge clk);
        pal_we_i   = 1'b0;
    endtask

    // Frame-0 output statistics, sampled on the falling edge.
    bit mon_en = 1'b1;
    int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, fs_cnt = 0, first_de = -1;
    always @(negedge clk) begin
        if (mon_en && arstn && cyc >= PIPE && cyc < FRAME + PIPE) begin
            if (vga_hs_o)  hs_cnt <= hs_cnt + 1;
            if (!vga_vs_o) vs_cnt <= vs_cnt + 1;
            if (de_o)      de_cnt <= de_cnt + 1;
            if (frame_start_o) fs_cnt <= fs_cnt + 1;
            if (de_o && first_de < 0) first_de <= cyc;
        end
    end

    initial begin
        arstn = 1'b0;
        wr_valid_i = 1'b0; wr_x_i = '0; wr_y_i = '0; wr_data_i = '0;
        pal_we_i = 1'b0; pal_idx_i = '0; pal_data_i = '0; swap_req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", wr_ready_o, 0);
        chk("rst_hs", vga_hs_o, 0);
        chk("rst_vs", vga_vs_o, 1);
        chk("rst_de", de_o, 0);
        chk("rst_rgb", rgb_o, 0);
        chk("rst_fs", frame_start_o, 0);
        chk("rst_err", wr_err_o, 0);

        arstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", wr_ready_o, 1);

        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 10; x++)
                fb_write(x, y, 0);
        fb_write(0, 0, 1);
        chk("err_inrange", wr_err_o, 0);
        fb_write(9, 5, 3);
        fb_write(3, 2, 2);
        fb_write(10, 0, 1);
        chk("err_x_pulse", wr_err_o, 1);
        @(negedge clk);
        chk("err_x_clear", wr_err_o, 0);
        fb_write(2, 6, 3);
        chk("err_y_pulse", wr_err_o, 1);
        swap_req_i = 1'b1;
        @(negedge clk);
        swap_req_i = 1'b0;
        chk("err_y_clear", wr_err_o, 0);
        chk("ready_swap_ignored", wr_ready_o, 1);

        // Frame 0 raster statistics and sync phase.
        run_to(FRAME + HR + PIPE - 1);
        chk("hs_last_active", vga_hs_o, 1);
        run_to(FRAME + HR + PIPE);
        chk("hs_first_idle", vga_hs_o, 0);
        run_to(440);
        mon_en = 1'b0;
        chk("hs_active_clocks", hs_cnt, 48);
        chk("vs_active_clocks", vs_cnt, 54);
        chk("de_clocks", de_cnt, 240);
        chk("frame_start_count", fs_cnt, 1);
        chk("first_de_cycle", first_de, 89);

        // Frame 1 image.
        run_to(kpix(1, 0, 0));
        chk("px00_rgb", rgb_o, 12'hFFF);
        chk("px00_fs", frame_start_o, 1);
        chk("px00_de", de_o, 1);
        run_to(kpix(1, 1, 0));
        chk("px10_rgb", rgb_o, 12'hFFF);
        chk("px10_fs", frame_start_o, 0);
        run_to(kpix(1, 2, 0));
        chk("px20_rgb", rgb_o, 12'h000);
        run_to(kpix(1, 0, 0) + 21);
        chk("hblank_rgb", rgb_o, 12'h000);
        chk("hblank_de", de_o, 0);
        run_to(kpix(1, 1, 1));
        chk("px11_rgb", rgb_o, 12'hFFF);
        run_to(kpix(1, 0, 2));
        chk("dropped_write_rgb", rgb_o, 12'h000);
        run_to(kpix(1, 6, 4));
        chk("px64_rgb", rgb_o, 12'hF00);
        run_to(kpix(1, 18, 10));
        chk("px18_10_rgb", rgb_o, 12'h0F0);
        run_to(kpix(1, 19, 11));
        chk("px19_11_rgb", rgb_o, 12'h0F0);

        // Palette rewrite, including a write racing a lookup of the same entry.
        pal_write(1, 12'h123);
        run_to(kpix(2, 0, 0));
        chk("pal_new_white", rgb_o, 12'h123);
        pal_write(1, 12'h456);
        chk("pal_same_cycle_old", rgb_o, 12'h123);
        run_to(kpix(2, 0, 1));
        chk("pal_second_write", rgb_o, 12'h456);
        run_to(kpix(2, 6, 4));
        chk("pal_other_entry", rgb_o, 12'hF00);

        // Framebuffer write colliding with the display read of the same address.
        run_to(kpix(3, 0, 0) - 2);
        fb_write(0, 0, 0);
        run_to(kpix(3, 0, 0));
        chk("raw_old_value", rgb_o, 12'h456);
        run_to(kpix(3, 1, 0));
        chk("raw_new_value", rgb_o, 12'h000);
        chk("pre_rst_de", de_o, 1);

        // Mid-frame reset.
        arstn = 1'b0;
        #1;
        chk("midrst_de", de_o, 0);
        chk("midrst_rgb", rgb_o, 0);
        chk("midrst_hs", vga_hs_o, 0);
        chk("midrst_vs", vga_vs_o, 1);
        chk("midrst_ready", wr_ready_o, 0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        fb_write(1, 0, 1);
        run_to(kpix(0, 0, 0) - 1);
        chk("restart_de_before", de_o, 0);
        run_to(kpix(0, 0, 0));
        chk("restart_de", de_o, 1);
        chk("restart_fs", frame_start_o, 1);
        chk("restart_px00", rgb_o, 12'h000);
        run_to(kpix(0, 2, 0));
        chk("restart_pal_white", rgb_o, 12'hFFF);
        run_to(kpix(0, 6, 4));
        chk("restart_px64", rgb_o, 12'hF00);
        run_to(kpix(0, 18, 10));
        chk("restart_px18_10", rgb_o, 12'h0F0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
